// File: rtl/johnson_decoder_mon.sv
// johnson_decoder_mon: receive-side monitor for a WIDTH-bit Johnson code stream.
// Decodes each valid sample to its ring position, flags illegal codes, and
// tracks +1 continuity to report lock / loss-of-lock.
// Optional macro JDEC_ERR_CNT_EN builds a saturating error counter on err_cnt;
// without it err_cnt is tied to 0.
//
// Handshake: in_valid qualifies count for one cycle, with no backpressure.
// All outputs update on the clock edge that samples in_valid=1. With
// in_valid=0, state holds and the error pulses drop to 0.
//
// fsm_state exposes the FSM state: 0=UNLOCK, 1=ACQ, 2=LOCKED.
module johnson_decoder_mon #(
   parameter  int WIDTH    = 3,
   parameter  int LOCK_CNT = 3,
   parameter  int ERR_W    = 8,
   localparam int IW       = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] count,
   output logic [IW-1:0]    index,
   output logic             code_ok,
   output logic             locked,
   output logic             seq_err,
   output logic             ill_err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      S_UNLOCK = 2'd0,
      S_ACQ    = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [IW-1:0]    LAST_IDX = IW'(2*WIDTH-1);
   localparam logic [IW-1:0]    RING_LEN = IW'(2*WIDTH);
   localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);

   state_t          state_q, state_d;
   logic [3:0]      run_q, run_d;
   // The previous ring position is always equal to the published index,
   // so index_q serves as both.
   logic [IW-1:0]   index_q, index_d;
   logic            ok_q, ok_d;
   logic            seq_q, seq_d;
   logic            ill_q, ill_d;

   logic [IW-1:0]   ones;
   logic            legal;
   logic [IW-1:0]   dec_idx;
   logic [IW-1:0]   step_idx;
   logic            is_step;
   logic            is_hold;

   // Decode the sampled code: legality, ones count and ring position.
   always_comb begin
      ones  = '0;
      legal = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + IW'(count[i]);
      end
      // Leading-ones form 1^k 0^(W-k), k = 0..W.
      for (int k = 0; k <= WIDTH; k++) begin
         if (count == ~(ALL_ONES >> k)) legal = 1'b1;
      end
      // Trailing-ones form 0^(W-k) 1^k, k = 1..W-1.
      for (int k = 1; k < WIDTH; k++) begin
         if (count == (ALL_ONES >> (WIDTH-k))) legal = 1'b1;
      end
      if (count == '0 || count[WIDTH-1]) dec_idx = ones;
      else                               dec_idx = RING_LEN - ones;
   end

   // Classify the decoded position against the previous one.
   always_comb begin
      step_idx = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
      is_step  = (dec_idx == step_idx);
      is_hold  = (dec_idx == index_q);
   end

   // Next-state and output logic for the lock FSM.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      index_d = index_q;
      ok_d    = ok_q;
      seq_d   = 1'b0;
      ill_d   = 1'b0;
      if (in_valid) begin
         if (!legal) begin
            ok_d    = 1'b0;
            ill_d   = 1'b1;
            state_d = S_UNLOCK;
            run_d   = '0;
         end else begin
            ok_d    = 1'b1;
            index_d = dec_idx;
            case (state_q)
               S_UNLOCK: begin
                  state_d = S_ACQ;
                  run_d   = '0;
               end
               S_ACQ: begin
                  if (is_step) begin
                     run_d = run_q + 4'd1;
                     if (run_q + 4'd1 == LOCK_N) state_d = S_LOCKED;
                  end else if (!is_hold) begin
                     run_d = '0;
                  end
               end
               S_LOCKED: begin
                  if (!is_step && !is_hold) begin
                     seq_d   = 1'b1;
                     state_d = S_ACQ;
                     run_d   = '0;
                  end
               end
               default: begin
                  state_d = S_UNLOCK;
                  run_d   = '0;
               end
            endcase
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_UNLOCK;
         run_q   <= '0;
         index_q <= '0;
         ok_q    <= 1'b0;
         seq_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         index_q <= index_d;
         ok_q    <= ok_d;
         seq_q   <= seq_d;
         ill_q   <= ill_d;
      end
   end

   assign index     = index_q;
   assign code_ok   = ok_q;
   assign locked    = (state_q == S_LOCKED);
   assign seq_err   = seq_q;
   assign ill_err   = ill_q;
   assign fsm_state = state_q;

`ifdef JDEC_ERR_CNT_EN
   logic [ERR_W-1:0] err_q;

   // Count error pulses in the same update that raises them; saturate at max.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= '0;
      end else if ((seq_d || ill_d) && (err_q != {ERR_W{1'b1}})) begin
         err_q <= err_q + 1'b1;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = '0;
`endif

endmodule
